boot_loader: RTL

- Upstream of the single-cycle core. Loads a program image from a byte stream, such as a UART receiver, into instruction memory through its write port.
- Holds the core in reset while loading. Releases the core only after a complete image with a valid checksum has been written.
- Frame format: SYNC byte, 16-bit word count (little-endian), count×4 payload bytes (each word little-endian), then a 1-byte XOR checksum of the payload bytes.

---
 rtl/boot_loader.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/boot_loader.sv
// Boot loader: receives a framed program image over a byte stream and writes
// it into instruction memory. The core is held in reset until a complete image
// with a matching XOR checksum has been written.
module boot_loader #(
   parameter int                    ADDR_WIDTH = 10,
   parameter logic [7:0]            SYNC_BYTE  = 8'hA5,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = {ADDR_WIDTH{1'b0}}
) (
   input  logic                  i_Clk,
   input  logic                  i_Reset_n,
   input  logic [7:0]            i_RxData,
   input  logic                  i_RxValid,
   output logic                  o_RxReady,
   output logic                  o_IMemWe,
   output logic [ADDR_WIDTH-1:0] o_IMemAddr,
   output logic [31:0]           o_IMemWData,
   output logic                  o_CoreReset,
   output logic                  o_Done,
   output logic                  o_Error
);

   // Largest legal word count; the length field is compared against it in 17 bits.
   localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LEN_LO = 3'd1,
      ST_LEN_HI = 3'd2,
      ST_DATA   = 3'd3,
      ST_CSUM   = 3'd4,
      ST_RUN    = 3'd5,
      ST_ERROR  = 3'd6
   } state_t;

   // Running XOR checksum over the payload bytes.
   function automatic logic [7:0] csum_update(input logic [7:0] csum, input logic [7:0] data);
      return csum ^ data;
   endfunction

   state_t                state_r, state_s;
   logic [15:0]           len_r, len_s;
   logic [1:0]            lane_r, lane_s;
   logic [ADDR_WIDTH-1:0] index_r, index_s;
   logic [23:0]           word_r, word_s;
   logic [7:0]            csum_r, csum_s;
   logic                  we_r, we_s;
   logic [ADDR_WIDTH-1:0] addr_r, addr_s;
   logic [31:0]           wdata_r, wdata_s;
   logic                  core_reset_r, core_reset_s;
   logic                  done_r, done_s;
   logic                  error_r, error_s;

   logic                  rx_ready_s;
   logic                  accept_s;
   logic [15:0]           len_full_s;
   logic                  last_word_s;

   // The loader takes bytes in every state except RUN; nothing is accepted while in reset.
   assign rx_ready_s  = (state_r != ST_RUN);
   assign o_RxReady   = rx_ready_s & i_Reset_n;
   assign accept_s    = i_RxValid & rx_ready_s;
   assign len_full_s  = {i_RxData, len_r[7:0]};
   assign last_word_s = (17'(index_r) == ({1'b0, len_r} - 17'd1));

   assign o_IMemWe    = we_r;
   assign o_IMemAddr  = addr_r;
   assign o_IMemWData = wdata_r;
   assign o_CoreReset = core_reset_r;
   assign o_Done      = done_r;
   assign o_Error     = error_r;

   // Next-state and next-datapath logic; everything advances only on an accepted byte.
   always_comb begin
      state_s      = state_r;
      len_s        = len_r;
      lane_s       = lane_r;
      index_s      = index_r;
      word_s       = word_r;
      csum_s       = csum_r;
      we_s         = 1'b0;
      addr_s       = addr_r;
      wdata_s      = wdata_r;
      core_reset_s = core_reset_r;
      done_s       = done_r;
      error_s      = error_r;
      if (accept_s) begin
         case (state_r)
            ST_IDLE: begin
               if (i_RxData == SYNC_BYTE) begin
                  state_s = ST_LEN_LO;
               end else begin
                  state_s = ST_IDLE;
               end
            end
            ST_LEN_LO: begin
               len_s[7:0] = i_RxData;
               state_s    = ST_LEN_HI;
            end
            ST_LEN_HI: begin
               len_s   = len_full_s;
               csum_s  = 8'h00;
               lane_s  = 2'd0;
               index_s = {ADDR_WIDTH{1'b0}};
               if ({1'b0, len_full_s} > MAX_WORDS) begin
                  state_s = ST_ERROR;
                  error_s = 1'b1;
               end else if (len_full_s == 16'h0000) begin
                  state_s = ST_CSUM;
               end else begin
                  state_s = ST_DATA;
               end
            end
            ST_DATA: begin
               csum_s = csum_update(csum_r, i_RxData);
               lane_s = lane_r + 2'd1;
               if (lane_r == 2'd3) begin
                  // Word complete: issue the write on the following cycle.
                  we_s    = 1'b1;
                  addr_s  = BASE_ADDR + index_r;
                  wdata_s = {i_RxData, word_r};
                  index_s = index_r + ADDR_WIDTH'(1);
                  if (last_word_s) begin
                     state_s = ST_CSUM;
                  end else begin
                     state_s = ST_DATA;
                  end
               end else begin
                  case (lane_r)
                     2'd0:    word_s[7:0]   = i_RxData;
                     2'd1:    word_s[15:8]  = i_RxData;
                     2'd2:    word_s[23:16] = i_RxData;
                     default: word_s        = word_r;
                  endcase
                  state_s = ST_DATA;
               end
            end
            ST_CSUM: begin
               if (i_RxData == csum_r) begin
                  state_s      = ST_RUN;
                  core_reset_s = 1'b0;
                  done_s       = 1'b1;
               end else begin
                  state_s = ST_ERROR;
                  error_s = 1'b1;
               end
            end
            ST_RUN: begin
               state_s = ST_RUN;
            end
            ST_ERROR: begin
               // Only a fresh sync byte gets us out; the core stays held.
               if (i_RxData == SYNC_BYTE) begin
                  state_s = ST_LEN_LO;
                  error_s = 1'b0;
               end else begin
                  state_s = ST_ERROR;
               end
            end
            default: begin
               state_s = ST_IDLE;
            end
         endcase
      end else begin
         state_s = state_r;
      end
   end

   // State and datapath registers; async reset abandons any frame in flight.
   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         state_r      <= ST_IDLE;
         len_r        <= 16'h0000;
         lane_r       <= 2'd0;
         index_r      <= {ADDR_WIDTH{1'b0}};
         word_r       <= 24'h000000;
         csum_r       <= 8'h00;
         we_r         <= 1'b0;
         addr_r       <= {ADDR_WIDTH{1'b0}};
         wdata_r      <= 32'h0000_0000;
         core_reset_r <= 1'b1;
         done_r       <= 1'b0;
         error_r      <= 1'b0;
      end else begin
         state_r      <= state_s;
         len_r        <= len_s;
         lane_r       <= lane_s;
         index_r      <= index_s;
         word_r       <= word_s;
         csum_r       <= csum_s;
         we_r         <= we_s;
         addr_r       <= addr_s;
         wdata_r      <= wdata_s;
         core_reset_r <= core_reset_s;
         done_r       <= done_s;
         error_r      <= error_s;
      end
   end

endmodule
